// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// decoded opcodes and the datapath mux-select / ALUOp codes.
// Imported by the interface, the controller and its retire counter.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXECUTE  = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: opcode and memory-ready in, all control
// strobes/selects plus debug/status out. master = controller side,
// slave = datapath side.
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                MemtoReg;
    logic                IRWrite;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [ALUOP_W-1:0]  ALUOp;
    logic [1:0]          PCSource;
    logic [3:0]          state;
    logic                instr_done;
    logic                illegal_op;
    logic [CNT_W-1:0]    retired_count;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, instr_done, illegal_op, retired_count
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, instr_done, illegal_op, retired_count
    );
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: counts cycles with inc high, wraps modulo 2^CNT_W.
// Latency: count reflects an increment one clock after inc.
// Backpressure: none; inc is taken every cycle it is asserted.
// Ports: clk, rst_n (async active-low clear), inc (enable), count.
module mc_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM (Moore) with sticky illegal-opcode flag and retire counter.
// Latency: lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles when memory is always ready.
// Backpressure: FETCH, MEM_RD and MEM_WR stall one cycle per cycle mem_ready is low.
// Ports: clk, reset (async active-low), bus (multicycle_control_if.master):
//   in opcode/mem_ready; out datapath strobes/selects, state, instr_done,
//   illegal_op, retired_count.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W      = 6,
    parameter int ALUOP_W       = 2,
    parameter int CNT_W         = 32,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ENABLE_ADDI   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_t     curState, nxtState;
    logic       rdy;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memtoReg;
    logic       irWrite, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       doneRaw, illegalSet, illegalQ;

    assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) curState <= S_FETCH;
        else        curState <= nxtState;
    end

    always_comb begin
        nxtState    = S_FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memtoReg    = 1'b0;
        irWrite     = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_B;
        aluOp       = ALUOP_ADD;
        pcSource    = PCSRC_ALU;
        doneRaw     = 1'b0;
        illegalSet  = 1'b0;
        case (curState)
            S_FETCH: begin
                memRead  = 1'b1;
                aluSrcB  = SRCB_FOUR;
                // IR and PC only load on the cycle memory delivers the word.
                irWrite  = rdy;
                pcWrite  = rdy;
                nxtState = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculative branch-target add while the opcode is decoded.
                aluSrcB = SRCB_IMM_SH2;
                if (bus.opcode == OPCODE_W'(OP_RTYPE))
                    nxtState = S_EXECUTE;
                else if (bus.opcode == OPCODE_W'(OP_LW) || bus.opcode == OPCODE_W'(OP_SW))
                    nxtState = S_MEM_ADDR;
                else if (bus.opcode == OPCODE_W'(OP_BEQ))
                    nxtState = S_BRANCH;
                else if (bus.opcode == OPCODE_W'(OP_J))
                    nxtState = S_JUMP;
                else if (ENABLE_ADDI && bus.opcode == OPCODE_W'(OP_ADDI))
                    nxtState = S_ADDI_EX;
                else begin
                    // Abandon the instruction without retiring it.
                    nxtState   = S_FETCH;
                    illegalSet = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                aluSrcA  = 1'b1;
                aluSrcB  = SRCB_IMM;
                nxtState = (bus.opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                memRead  = 1'b1;
                iorD     = 1'b1;
                nxtState = rdy ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                memtoReg = 1'b1;
                regWrite = 1'b1;
                doneRaw  = 1'b1;
            end
            S_MEM_WR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                doneRaw  = rdy;
                nxtState = rdy ? S_FETCH : S_MEM_WR;
            end
            S_EXECUTE: begin
                aluSrcA  = 1'b1;
                aluOp    = ALUOP_FUNCT;
                nxtState = S_R_WB;
            end
            S_R_WB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                doneRaw  = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
                doneRaw     = 1'b1;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
                doneRaw  = 1'b1;
            end
            S_ADDI_EX: begin
                aluSrcA  = 1'b1;
                aluSrcB  = SRCB_IMM;
                nxtState = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                regWrite = 1'b1;
                doneRaw  = 1'b1;
            end
            default: nxtState = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          illegalQ <= 1'b0;
        else if (illegalSet) illegalQ <= 1'b1;
    end

    mc_retire_counter #(.CNT_W(CNT_W)) u_retire (
        .clk   (clk),
        .rst_n (reset),
        .inc   (doneRaw),
        .count (bus.retired_count)
    );

    // Write strobes are gated by reset itself so an abort never leaves a
    // partial write on the bus, even before the state register settles.
    assign bus.PCWrite     = pcWrite & reset;
    assign bus.PCWriteCond = pcWriteCond & reset;
    assign bus.IRWrite     = irWrite & reset;
    assign bus.RegWrite    = regWrite & reset;
    assign bus.MemWrite    = memWrite & reset;
    assign bus.MemRead     = memRead & reset;
    assign bus.instr_done  = doneRaw & reset;
    assign bus.IorD        = iorD;
    assign bus.MemtoReg    = memtoReg;
    assign bus.RegDst      = regDst;
    assign bus.ALUSrcA     = aluSrcA;
    assign bus.ALUSrcB     = aluSrcB;
    assign bus.ALUOp       = ALUOP_W'(aluOp);
    assign bus.PCSource    = pcSource;
    assign bus.state       = curState;
    assign bus.illegal_op  = illegalQ;
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(32)) bus0 ();
    multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(4))  bus1 ();

    multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(32),
                         .MEM_HANDSHAKE(1'b1), .ENABLE_ADDI(1'b1))
        dut0 (.clk(clk), .reset(rst0), .bus(bus0));

    multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(4),
                         .MEM_HANDSHAKE(1'b1), .ENABLE_ADDI(1'b0))
        dut1 (.clk(clk), .reset(rst1), .bus(bus1));

    int nChk = 0;
    int nErr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected per-instruction record: state trace (one hex digit per cycle),
    // cycle count, RegWrite/IRWrite cycle counts, retired_count before retiring.
    typedef struct {
        logic [63:0] trace;
        int          len;
        int          regw;
        int          irw;
        logic [31:0] ret;
    } exp_t;

    exp_t        sbq[$];
    exp_t        ex;
    logic [31:0] expRet = 0;

    // Monitor for dut0: collects the state trace from each FETCH entry and
    // scores it when instr_done pulses.
    logic [63:0] trace;
    int          tlen, nRegw, nIrw;
    logic [3:0]  prevSt;

    always @(negedge clk) begin
        if (!rst0) begin
            prevSt = 4'hF;
            trace = '0; tlen = 0; nRegw = 0; nIrw = 0;
        end else begin
            if (bus0.state == 4'd0 && prevSt != 4'd0) begin
                trace = '0; tlen = 0; nRegw = 0; nIrw = 0;
            end
            trace = {trace[59:0], bus0.state};
            tlen++;
            if (bus0.RegWrite) nRegw++;
            if (bus0.IRWrite)  nIrw++;
            if (bus0.instr_done) begin
                if (sbq.size() == 0) begin
                    nChk++; nErr++;
                    $display("FAIL unexpected_done: got instr_done in state %0d, required none", bus0.state);
                end else begin
                    ex = sbq.pop_front();
                    chk("sb_trace",   trace, ex.trace);
                    chk("sb_len",     64'(tlen), 64'(ex.len));
                    chk("sb_regw",    64'(nRegw), 64'(ex.regw));
                    chk("sb_irw",     64'(nIrw), 64'(ex.irw));
                    chk("sb_retired", 64'(bus0.retired_count), 64'(ex.ret));
                end
            end
            prevSt = bus0.state;
        end
    end

    // Runs one instruction on dut0 from FETCH; fw = not-ready cycles in FETCH,
    // mw = not-ready cycles in MEM_RD/MEM_WR. Called at posedge+1 in FETCH.
    task automatic issue(input logic [5:0] op, input int fw, input int mw,
                         input logic [63:0] tr, input int len, input int rw);
        exp_t e;
        e.trace = tr; e.len = len; e.regw = rw; e.irw = 1; e.ret = expRet;
        sbq.push_back(e);
        expRet++;
        bus0.opcode = op;
        for (int c = 0; c < len; c++) begin
            bus0.mem_ready = 1'b1;
            if (c < fw) bus0.mem_ready = 1'b0;
            else if (c >= fw + 3 && c < fw + 3 + mw) bus0.mem_ready = 1'b0;
            @(posedge clk); #1;
        end
        bus0.mem_ready = 1'b1;
    endtask

    initial begin
        exp_t e;
        rst0 = 1'b0; rst1 = 1'b0;
        bus0.opcode = 6'h00; bus0.mem_ready = 1'b1;
        bus1.opcode = 6'h08; bus1.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",   64'(bus0.state), 64'd0);
        chk("rst_memread", 64'(bus0.MemRead), 64'd0);
        chk("rst_irwrite", 64'(bus0.IRWrite), 64'd0);
        chk("rst_pcwrite", 64'(bus0.PCWrite), 64'd0);
        chk("rst_alusrcb", 64'(bus0.ALUSrcB), 64'd1);
        chk("rst_retired", 64'(bus0.retired_count), 64'd0);
        chk("rst_illegal", 64'(bus0.illegal_op), 64'd0);
        rst0 = 1'b1;

        // Back-to-back mix with memory always ready: 4+5+4+3+3+4 = 23 cycles.
        issue(6'h00, 0, 0, 64'h0167,  4, 1);
        issue(6'h23, 0, 0, 64'h01234, 5, 1);
        issue(6'h2B, 0, 0, 64'h0125,  4, 0);
        issue(6'h04, 0, 0, 64'h018,   3, 0);
        issue(6'h02, 0, 0, 64'h019,   3, 0);
        issue(6'h08, 0, 0, 64'h01AB,  4, 1);
        chk("mix_state",   64'(bus0.state), 64'd0);
        chk("mix_retired", 64'(bus0.retired_count), 64'd6);

        // lw with 2 FETCH waits and 3 MEM_RD waits: 10 cycles.
        issue(6'h23, 2, 3, 64'h0001233334, 10, 1);
        chk("lwwait_retired", 64'(bus0.retired_count), 64'd7);

        // Illegal opcode: FETCH, DECODE, back to FETCH, sticky flag.
        bus0.opcode = 6'h3F;
        @(posedge clk); #1;
        chk("ill_decode", 64'(bus0.state), 64'd1);
        chk("ill_nodone", 64'(bus0.instr_done), 64'd0);
        @(posedge clk); #1;
        chk("ill_fetch",   64'(bus0.state), 64'd0);
        chk("ill_flag",    64'(bus0.illegal_op), 64'd1);
        chk("ill_retired", 64'(bus0.retired_count), 64'd7);
        issue(6'h02, 0, 0, 64'h019, 3, 0);
        chk("ill_sticky",  64'(bus0.illegal_op), 64'd1);
        chk("ill_after_j", 64'(bus0.retired_count), 64'd8);

        // sw stalled in MEM_WR, then reset mid-instruction.
        bus0.opcode = 6'h2B; bus0.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus0.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("memwr_state", 64'(bus0.state), 64'd5);
        chk("memwr_we",    64'(bus0.MemWrite), 64'd1);
        rst0 = 1'b0;
        #1;
        chk("abort_we",      64'(bus0.MemWrite), 64'd0);
        chk("abort_state",   64'(bus0.state), 64'd0);
        chk("abort_retired", 64'(bus0.retired_count), 64'd0);
        chk("abort_illegal", 64'(bus0.illegal_op), 64'd0);
        expRet = 0;
        bus0.opcode = 6'h02; bus0.mem_ready = 1'b1;
        e.trace = 64'h019; e.len = 3; e.regw = 0; e.irw = 1; e.ret = 0;
        sbq.push_back(e);
        @(posedge clk); #3;
        rst0 = 1'b1;
        @(posedge clk); #1;
        chk("release_decode", 64'(bus0.state), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("release_j_state",   64'(bus0.state), 64'd0);
        chk("release_j_retired", 64'(bus0.retired_count), 64'd1);
        rst0 = 1'b0;

        // dut1: addi disabled, 4-bit counter.
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        chk("noaddi_decode", 64'(bus1.state), 64'd1);
        @(posedge clk); #1;
        chk("noaddi_fetch",   64'(bus1.state), 64'd0);
        chk("noaddi_illegal", 64'(bus1.illegal_op), 64'd1);
        chk("noaddi_retired", 64'(bus1.retired_count), 64'd0);
        rst1 = 1'b0;
        #1;
        chk("dut1_rst_illegal", 64'(bus1.illegal_op), 64'd0);
        bus1.opcode = 6'h02;
        @(posedge clk); #1;
        rst1 = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        chk("wrap_15", 64'(bus1.retired_count), 64'd15);
        repeat (6) @(posedge clk);
        #1;
        chk("wrap_17_state", 64'(bus1.state), 64'd0);
        chk("wrap_17",       64'(bus1.retired_count), 64'd1);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule
